// File: rtl/cofi_pkg.sv
// Shared types and constants for the composite-blend enable controller.
// Holds the user-mode and FSM encodings plus the default auto-mode width threshold.
package cofi_pkg;

    typedef enum logic [1:0] {
        ModeOff  = 2'd0,
        ModeOn   = 2'd1,
        ModeAuto = 2'd2
    } cofi_mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StMeasure,
        StLocked
    } cofi_state_e;

    localparam int unsigned DefaultThresh = 300;
    localparam int unsigned StableCntW    = 4;

endpackage

// File: rtl/cofi_width_meter.sv
// Measures the active line width within one frame, qualified by pix_ce.
// Reports the first line's width and whether every captured line agreed with it.
module cofi_width_meter #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             pix_ce_i,
    input  logic             hblank_i,
    input  logic             vblank_i,
    output logic             vrise_o,
    output logic             good_o,
    output logic [CNT_W-1:0] first_w_o
);

    logic             hblank_q, vblank_q;
    logic [CNT_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] first_w_q, first_w_d;
    logic             seen_q, seen_d;
    logic             mismatch_q, mismatch_d;
    logic             hrise, vrise, capture;

    always_comb begin
        hrise   = pix_ce_i & hblank_i & ~hblank_q;
        vrise   = pix_ce_i & vblank_i & ~vblank_q;
        capture = hrise & ~vblank_i & (pc_q != '0);

        pc_d = pc_q;
        if (hrise) begin
            pc_d = '0;
        end else if (pix_ce_i && !hblank_i && !vblank_i && (pc_q != '1)) begin
            pc_d = pc_q + 1'b1;
        end

        first_w_d  = first_w_q;
        seen_d     = seen_q;
        mismatch_d = mismatch_q;
        if (capture) begin
            if (!seen_q) begin
                first_w_d = pc_q;
                seen_d    = 1'b1;
            end else if (pc_q != first_w_q) begin
                mismatch_d = 1'b1;
            end
        end
        // Capture needs vblank low and vrise needs it high, so they never collide.
        if (vrise) begin
            seen_d     = 1'b0;
            mismatch_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hblank_q   <= 1'b0;
            vblank_q   <= 1'b0;
            pc_q       <= '0;
            first_w_q  <= '0;
            seen_q     <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            if (pix_ce_i) begin
                hblank_q <= hblank_i;
                vblank_q <= vblank_i;
            end
            pc_q       <= pc_d;
            first_w_q  <= first_w_d;
            seen_q     <= seen_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign vrise_o   = vrise;
    assign good_o    = seen_q & ~mismatch_q;
    assign first_w_o = first_w_q;

endmodule

// File: rtl/cofi_ctrl.sv
// Frame-synchronous enable controller for the horizontal blender.
// Tracks width stability over frames and applies the user mode only at vblank rise.
module cofi_ctrl
    import cofi_pkg::*;
#(
    parameter int unsigned CNT_W         = 10,
    parameter int unsigned STABLE_FRAMES = 3,
    parameter int unsigned THRESH        = DefaultThresh
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             pix_ce_i,
    input  logic             hblank_i,
    input  logic             vblank_i,
    input  logic [1:0]       user_mode_i,
    output logic             enable_o,
    output logic [CNT_W-1:0] line_width_o,
    output logic             locked_o
);

    localparam logic [StableCntW-1:0] StableMax = StableCntW'(STABLE_FRAMES);

    logic                  vrise, good;
    logic [CNT_W-1:0]      first_w;

    cofi_state_e           state_q;
    logic [CNT_W-1:0]      cand_q, cand_n;
    logic [StableCntW-1:0] stable_q, stable_n;
    logic                  locked_q, locked_n;
    logic                  enable_q, enable_n;

    cofi_width_meter #(
        .CNT_W(CNT_W)
    ) u_meter (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .pix_ce_i (pix_ce_i),
        .hblank_i (hblank_i),
        .vblank_i (vblank_i),
        .vrise_o  (vrise),
        .good_o   (good),
        .first_w_o(first_w)
    );

    // Result of evaluating the frame that ends at this vrise.
    always_comb begin
        cand_n   = cand_q;
        stable_n = '0;
        if (good) begin
            if (first_w == cand_q) begin
                stable_n = (stable_q == StableMax) ? stable_q : stable_q + 1'b1;
            end else begin
                cand_n = first_w;
            end
        end
        locked_n = (stable_n == StableMax);

        case (user_mode_i)
            ModeOn:   enable_n = 1'b1;
            ModeAuto: enable_n = locked_n ? (32'(cand_n) < THRESH) : enable_q;
            default:  enable_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= StIdle;
            cand_q   <= '0;
            stable_q <= '0;
            locked_q <= 1'b0;
            enable_q <= 1'b0;
        end else if (vrise) begin
            unique case (state_q)
                StIdle: begin
                    state_q <= StMeasure;
                end
                StMeasure, StLocked: begin
                    cand_q   <= cand_n;
                    stable_q <= stable_n;
                    locked_q <= locked_n;
                    enable_q <= enable_n;
                    state_q  <= locked_n ? StLocked : StMeasure;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign enable_o     = enable_q;
    assign line_width_o = cand_q;
    assign locked_o     = locked_q;

endmodule
